// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine datapath: coin encodings,
// coin values and the change dispenser state encoding.
package vending_pkg;

   // Coin type encodings driven on coin_sel (3 is never used)
   localparam logic [1:0] COIN_SEL_LO  = 2'd0;
   localparam logic [1:0] COIN_SEL_MID = 2'd1;
   localparam logic [1:0] COIN_SEL_HI  = 2'd2;

   // Coin face values
   localparam int COIN_VAL_HI  = 5;
   localparam int COIN_VAL_MID = 2;
   localparam int COIN_VAL_LO  = 1;

   // Change dispenser controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SELECT = 3'd2,
      ST_REQ    = 3'd3,
      ST_DONE   = 3'd4,
      ST_FAULT  = 3'd5
   } disp_state_t;

endpackage

// File: rtl/coin_picker.sv
// Greedy coin selection: returns the largest coin whose value does not
// exceed the amount still owed. Purely combinational.
module coin_picker
   import vending_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int COIN_HI  = COIN_VAL_HI,
   parameter int COIN_MID = COIN_VAL_MID,
   parameter int COIN_LO  = COIN_VAL_LO
)(
   input  logic [WIDTH-1:0] amount,
   output logic [1:0]       coin_sel,
   output logic [WIDTH-1:0] coin_val
);

   // Try coins from largest to smallest; the small coin is the fallback
   always_comb begin
      coin_sel = COIN_SEL_LO;
      coin_val = WIDTH'(COIN_LO);
      if (amount >= WIDTH'(COIN_HI)) begin
         coin_sel = COIN_SEL_HI;
         coin_val = WIDTH'(COIN_HI);
      end else if (amount >= WIDTH'(COIN_MID)) begin
         coin_sel = COIN_SEL_MID;
         coin_val = WIDTH'(COIN_MID);
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: on a purchase request either refuses it (credit below
// price) or vends the item and pays the change one coin at a time through
// a req/ack handshake with the coin ejector. A stalled ejector latches a
// sticky fault that only reset clears. All outputs are registered.
module change_dispenser
   import vending_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int COIN_HI     = COIN_VAL_HI,
   parameter int COIN_MID    = COIN_VAL_MID,
   parameter int COIN_LO     = COIN_VAL_LO,
   parameter int ACK_TIMEOUT = 15
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] diff,
   input  logic             no_borrow,
   output logic             busy,
   output logic             vend,
   output logic             insufficient,
   output logic             coin_req,
   output logic [1:0]       coin_sel,
   input  logic             coin_ack,
   output logic [WIDTH-1:0] remaining,
   output logic             done,
   output logic             fault
);

   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

   disp_state_t      state, state_d;
   logic             nb_q, nb_d;
   logic [WIDTH-1:0] coin_val, coin_val_d;
   logic [TMR_W-1:0] timer, timer_d;
   logic [WIDTH-1:0] remaining_d;
   logic [1:0]       coin_sel_d;
   logic             busy_d, vend_d, insufficient_d, coin_req_d, done_d, fault_d;
   logic [1:0]       pick_sel;
   logic [WIDTH-1:0] pick_val;

   coin_picker #(
      .WIDTH    (WIDTH),
      .COIN_HI  (COIN_HI),
      .COIN_MID (COIN_MID),
      .COIN_LO  (COIN_LO)
   ) u_picker (
      .amount   (remaining),
      .coin_sel (pick_sel),
      .coin_val (pick_val)
   );

   // State and registered outputs; reset aborts any payout in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         nb_q         <= 1'b0;
         coin_val     <= '0;
         timer        <= '0;
         remaining    <= '0;
         coin_sel     <= COIN_SEL_LO;
         busy         <= 1'b0;
         vend         <= 1'b0;
         insufficient <= 1'b0;
         coin_req     <= 1'b0;
         done         <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state        <= state_d;
         nb_q         <= nb_d;
         coin_val     <= coin_val_d;
         timer        <= timer_d;
         remaining    <= remaining_d;
         coin_sel     <= coin_sel_d;
         busy         <= busy_d;
         vend         <= vend_d;
         insufficient <= insufficient_d;
         coin_req     <= coin_req_d;
         done         <= done_d;
         fault        <= fault_d;
      end
   end

   // Next-state and next-output logic; pulses default low, levels hold
   always_comb begin
      state_d        = state;
      nb_d           = nb_q;
      coin_val_d     = coin_val;
      timer_d        = timer;
      remaining_d    = remaining;
      coin_sel_d     = coin_sel;
      coin_req_d     = coin_req;
      fault_d        = fault;
      vend_d         = 1'b0;
      insufficient_d = 1'b0;
      done_d         = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) begin
               remaining_d = diff;
               nb_d        = no_borrow;
               state_d     = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!nb_q) begin
               insufficient_d = 1'b1;
               remaining_d    = '0;
               state_d        = ST_IDLE;
            end else begin
               vend_d  = 1'b1;
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (remaining == '0) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               coin_sel_d = pick_sel;
               coin_val_d = pick_val;
               coin_req_d = 1'b1;
               timer_d    = '0;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            // An ack on the final allowed cycle still counts as success
            if (coin_ack) begin
               remaining_d = remaining - coin_val;
               coin_req_d  = 1'b0;
               timer_d     = '0;
               state_d     = ST_SELECT;
            end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
               coin_req_d = 1'b0;
               fault_d    = 1'b1;
               state_d    = ST_FAULT;
            end else begin
               timer_d = timer + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // busy also covers the cycle in which a refusal is reported
      busy_d = (state_d != ST_IDLE) | insufficient_d;
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a table of purchase transactions
// with hand-computed coin sequences and timing, plus hand-written
// sequences for timeout, reset mid-payout and ignored inputs.
module tb_change_dispenser;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] diff;
   logic       no_borrow;
   logic       busy;
   logic       vend;
   logic       insufficient;
   logic       coin_req;
   logic [1:0] coin_sel;
   logic       coin_ack;
   logic [3:0] remaining;
   logic       done;
   logic       fault;

   int n_checks = 0;
   int n_errors = 0;

   change_dispenser dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .diff         (diff),
      .no_borrow    (no_borrow),
      .busy         (busy),
      .vend         (vend),
      .insufficient (insufficient),
      .coin_req     (coin_req),
      .coin_sel     (coin_sel),
      .coin_ack     (coin_ack),
      .remaining    (remaining),
      .done         (done),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0]      d;
      logic            nb;
      int              dly;
      int              vends;
      int              ins;
      int              dones;
      int              ncoins;
      logic [3:0][1:0] sel;
      logic [3:0][3:0] rem;
      int              vend_k;
      int              ins_k;
      int              done_k;
      int              low_k;
   } vec_t;

   vec_t vecs[7];

   // Transaction observations
   int              r_vends, r_ins, r_dones, r_n;
   int              r_vend_k, r_ins_k, r_done_k, r_low_k;
   logic [3:0][1:0] r_sel;
   logic [3:0][3:0] r_rem;
   logic            r_req_after_done, r_bad_sel, r_fault;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int got, input int expv);
      n_checks++;
      if (got != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, expv);
      end
   endtask

   function automatic logic [3:0][1:0] pk_sel(input int a, input int b, input int c, input int e);
      logic [3:0][1:0] r;
      r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(e);
      return r;
   endfunction

   function automatic logic [3:0][3:0] pk_rem(input int a, input int b, input int c, input int e);
      logic [3:0][3:0] r;
      r[0] = 4'(a); r[1] = 4'(b); r[2] = 4'(c); r[3] = 4'(e);
      return r;
   endfunction

   // Runs one purchase; k counts edges after the accepting edge N (k=0).
   // Each coin is acked once it has been requested for dly+1 cycles.
   task automatic run_txn(input logic [3:0] d, input logic nb, input int dly);
      int  k;
      int  wt;
      logic prev;
      r_vends = 0; r_ins = 0; r_dones = 0; r_n = 0;
      r_vend_k = -1; r_ins_k = -1; r_done_k = -1; r_low_k = -1;
      r_sel = '0; r_rem = '0;
      r_req_after_done = 1'b0; r_bad_sel = 1'b0; r_fault = 1'b0;
      start = 1'b1; diff = d; no_borrow = nb;
      tick();
      start = 1'b0;
      k = 0; wt = 0; prev = 1'b0;
      while (k < 200) begin
         if (vend) begin r_vends++; r_vend_k = k; end
         if (insufficient) begin r_ins++; r_ins_k = k; end
         if (done) begin r_dones++; r_done_k = k; end
         if (coin_req && r_dones > 0) r_req_after_done = 1'b1;
         if (coin_sel == 2'd3) r_bad_sel = 1'b1;
         if (fault) r_fault = 1'b1;
         if (coin_req) begin
            if (!prev && r_n < 4) r_sel[r_n] = coin_sel;
            if (wt == dly) coin_ack = 1'b1;
            wt++;
         end
         if (!busy || fault) begin
            r_low_k = k;
            break;
         end
         prev = coin_req;
         tick();
         k++;
         if (coin_ack) begin
            coin_ack = 1'b0;
            if (r_n < 4) r_rem[r_n] = remaining;
            r_n++;
            wt = 0;
         end
      end
   endtask

   initial begin
      int reqc;
      logic saw_vend;

      //                 d   nb dly vnd ins dn  n  sel                  rem                    vk  ik  dk  lk
      vecs[0] = '{4'd13, 1'b1, 0,  1, 0, 1, 4, pk_sel(2,2,1,0), pk_rem(8,3,1,0),   1, -1, 10, 11};
      vecs[1] = '{4'd9,  1'b0, 0,  0, 1, 0, 0, pk_sel(0,0,0,0), pk_rem(0,0,0,0),  -1,  1, -1,  2};
      vecs[2] = '{4'd0,  1'b1, 0,  1, 0, 1, 0, pk_sel(0,0,0,0), pk_rem(0,0,0,0),   1, -1,  2,  3};
      vecs[3] = '{4'd15, 1'b1, 2,  1, 0, 1, 3, pk_sel(2,2,2,0), pk_rem(10,5,0,0),  1, -1, 14, 15};
      vecs[4] = '{4'd6,  1'b1, 0,  1, 0, 1, 2, pk_sel(2,0,0,0), pk_rem(1,0,0,0),   1, -1,  6,  7};
      vecs[5] = '{4'd7,  1'b1, 1,  1, 0, 1, 2, pk_sel(2,1,0,0), pk_rem(2,0,0,0),   1, -1,  8,  9};
      vecs[6] = '{4'd15, 1'b1, 14, 1, 0, 1, 3, pk_sel(2,2,2,0), pk_rem(10,5,0,0),  1, -1, 50, 51};

      rst = 1'b1; start = 1'b0; diff = 4'd0; no_borrow = 1'b0; coin_ack = 1'b0;
      tick();
      tick();
      chk("reset busy", int'(busy), 0);
      chk("reset vend", int'(vend), 0);
      chk("reset insufficient", int'(insufficient), 0);
      chk("reset coin_req", int'(coin_req), 0);
      chk("reset coin_sel", int'(coin_sel), 0);
      chk("reset remaining", int'(remaining), 0);
      chk("reset done", int'(done), 0);
      chk("reset fault", int'(fault), 0);
      rst = 1'b0;
      tick();

      // Table-driven transactions
      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i].d, vecs[i].nb, vecs[i].dly);
         chk($sformatf("v%0d vend count", i), r_vends, vecs[i].vends);
         chk($sformatf("v%0d insufficient count", i), r_ins, vecs[i].ins);
         chk($sformatf("v%0d done count", i), r_dones, vecs[i].dones);
         chk($sformatf("v%0d coin count", i), r_n, vecs[i].ncoins);
         chk($sformatf("v%0d coin_sel seq", i), int'(r_sel), int'(vecs[i].sel));
         chk($sformatf("v%0d remaining seq", i), int'(r_rem), int'(vecs[i].rem));
         chk($sformatf("v%0d vend cycle", i), r_vend_k, vecs[i].vend_k);
         chk($sformatf("v%0d insufficient cycle", i), r_ins_k, vecs[i].ins_k);
         chk($sformatf("v%0d done cycle", i), r_done_k, vecs[i].done_k);
         chk($sformatf("v%0d busy low cycle", i), r_low_k, vecs[i].low_k);
         chk($sformatf("v%0d coin_req after done", i), int'(r_req_after_done), 0);
         chk($sformatf("v%0d coin_sel 3 seen", i), int'(r_bad_sel), 0);
         chk($sformatf("v%0d fault", i), int'(r_fault), 0);
         chk($sformatf("v%0d final remaining", i), int'(remaining), 0);
         tick();
         chk($sformatf("v%0d idle coin_req", i), int'(coin_req), 0);
         tick();
      end

      // Ejector never acks: fault after exactly 15 request cycles
      start = 1'b1; diff = 4'd15; no_borrow = 1'b1;
      tick();
      start = 1'b0;
      reqc = 0;
      for (int k = 0; k < 60; k++) begin
         if (fault) break;
         if (coin_req) reqc++;
         tick();
      end
      chk("timeout req cycles", reqc, 15);
      chk("timeout fault", int'(fault), 1);
      chk("timeout coin_req", int'(coin_req), 0);
      chk("timeout remaining", int'(remaining), 15);
      chk("timeout busy", int'(busy), 1);
      // A new purchase is ignored while faulted
      start = 1'b1; diff = 4'd3; no_borrow = 1'b1;
      tick();
      start = 1'b0;
      saw_vend = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (vend || coin_req) saw_vend = 1'b1;
         tick();
      end
      chk("fault ignores start", int'(saw_vend), 0);
      chk("fault sticky", int'(fault), 1);
      chk("fault remaining held", int'(remaining), 15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("fault cleared by rst", int'(fault), 0);
      chk("fault rst busy", int'(busy), 0);
      chk("fault rst remaining", int'(remaining), 0);
      tick();

      // Reset while the second coin is being requested
      start = 1'b1; diff = 4'd6; no_borrow = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("mid first coin_req", int'(coin_req), 1);
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
      chk("mid remaining after first", int'(remaining), 1);
      tick();
      chk("mid second coin_req", int'(coin_req), 1);
      chk("mid second coin_sel", int'(coin_sel), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid rst busy", int'(busy), 0);
      chk("mid rst vend", int'(vend), 0);
      chk("mid rst insufficient", int'(insufficient), 0);
      chk("mid rst coin_req", int'(coin_req), 0);
      chk("mid rst coin_sel", int'(coin_sel), 0);
      chk("mid rst remaining", int'(remaining), 0);
      chk("mid rst done", int'(done), 0);
      chk("mid rst fault", int'(fault), 0);
      tick();
      tick();
      chk("post rst coin_req", int'(coin_req), 0);
      chk("post rst busy", int'(busy), 0);

      // Start while busy is ignored
      start = 1'b1; diff = 4'd5; no_borrow = 1'b1;
      tick();
      diff = 4'd9; no_borrow = 1'b0;
      tick();
      start = 1'b0;
      chk("busy start vend", int'(vend), 1);
      chk("busy start insufficient", int'(insufficient), 0);
      tick();
      chk("busy start coin_req", int'(coin_req), 1);
      chk("busy start coin_sel", int'(coin_sel), 2);
      coin_ack = 1'b1;
      tick();
      coin_ack = 1'b0;
      chk("busy start remaining", int'(remaining), 0);
      tick();
      chk("busy start done", int'(done), 1);
      tick();
      chk("busy start busy low", int'(busy), 0);

      // Spurious ack in IDLE changes nothing
      coin_ack = 1'b1;
      tick();
      tick();
      coin_ack = 1'b0;
      chk("idle ack remaining", int'(remaining), 0);
      chk("idle ack coin_req", int'(coin_req), 0);
      chk("idle ack busy", int'(busy), 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream of the 4-bit parallel subtractor in the vending machine datapath.
- Consumes the difference (inserted credit minus item price) and the subtractor's carry-out, where 1 means credit >= price.
- On a purchase request it either signals insufficient funds, or vends the item and pays the change as a sequence of coins using a request/acknowledge handshake with the coin ejector.

Parameters:
- WIDTH, 4, width of the change amount (matches the subtractor).
- COIN_HI, 5, value of the large coin.
- COIN_MID, 2, value of the middle coin.
- COIN_LO, 1, value of the small coin.
- ACK_TIMEOUT, 15, maximum cycles coin_req may wait for coin_ack before a fault.

Ports:
- clk  input  1  system clock; single clock domain, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle purchase request pulse.
- diff  input  WIDTH  change amount from the subtractor.
- no_borrow  input  1  subtractor carry-out; 1 means credit >= price.
- busy  output  1  high from the edge that accepts start until the return to IDLE.
- vend  output  1  one-cycle pulse: release the item.
- insufficient  output  1  one-cycle pulse: purchase refused.
- coin_req  output  1  coin ejection request.
- coin_sel  output  2  coin type: 0=LO, 1=MID, 2=HI; 3 is never driven.
- coin_ack  input  1  ejector has dropped the requested coin.
- remaining  output  WIDTH  change still owed.
- done  output  1  one-cycle pulse: transaction complete.
- fault  output  1  sticky; the ejector timed out.

Behaviour:
- Reset: every output is 0, state is IDLE, the timer is 0. Reset in any state, including mid-payout, aborts immediately with no further coin_req.
- All outputs are registered.
- States: IDLE, CHECK, SELECT, REQ, DONE, FAULT.
- IDLE:
  - start sampled high at edge N latches diff into remaining and latches no_borrow.
  - busy is 1 after N. Next state is CHECK.
  - start is ignored in every state other than IDLE.
- CHECK, at edge N+1:
  - If latched no_borrow=0: insufficient=1 for one cycle, remaining cleared to 0, go to IDLE (busy drops after N+1). No vend, no coin_req.
  - Else: vend=1 for one cycle, go to SELECT.
- SELECT, one cycle:
  - If remaining=0: go to DONE; done=1 for one cycle during DONE.
  - Else pick the largest coin with value <= remaining, in the order HI, MID, LO. Drive coin_sel and coin_req=1 from the next edge, and go to REQ.
- REQ:
  - coin_req and coin_sel stay stable until coin_ack is sampled high at edge M.
  - At M: remaining -= coin value, coin_req=0, timer cleared, go to SELECT. The next coin_req rises at M+1 at the earliest.
- Timer:
  - Counts the cycles in which coin_req=1.
  - If no ack arrives by the edge that ends the ACK_TIMEOUT-th such cycle: go to FAULT, coin_req=0, fault=1.
  - If ack and timeout occur on the same edge, ack wins.
- FAULT: busy=1, fault=1, remaining holds its value. The state is left only by rst.
- DONE: lasts one cycle, then IDLE with busy=0.
- coin_ack outside REQ is ignored.
- Arithmetic: unsigned WIDTH-bit. Subtraction never underflows because of the selection rule. The maximum change is 15, paid as 5+5+5.
- Latency for change of 0: vend after N+1, done after N+2, busy low after N+3.

Decomposition:
- Shared package vending_pkg holds:
  - the coin_sel encodings (COIN_SEL_LO/MID/HI);
  - the coin value constants;
  - the state encoding for change_dispenser.
- One natural sub-module, coin_picker: combinational; takes remaining and returns coin_sel and coin value.

Test Plan:
- diff=13, no_borrow=1, immediate acks:
  - vend pulses once.
  - coin_sel sequence is 2,2,1,0 and remaining goes 13→8→3→1→0.
  - done pulses once, and no further coin_req follows.
- diff=9, no_borrow=0:
  - insufficient pulses one cycle after CHECK.
  - vend, coin_req and done stay 0; busy is high for exactly 2 cycles.
- diff=0, no_borrow=1:
  - vend after N+1, done after N+2, coin_req never rises.
- diff=15, no acks for 15 cycles after the first coin_req:
  - fault=1, coin_req=0, remaining=15.
  - A later start is ignored; only rst clears the fault.
  - Ack on exactly the 15th cycle: no fault, remaining=10.
- diff=6, rst asserted while coin_req is high for the second coin:
  - The next cycle shows every output at 0.
  - A start pulse during busy is ignored, and a spurious coin_ack in IDLE leaves remaining unchanged.
